// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle stage sequencer with ready wait states, timeout halt, single-step and counters
module cpu_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15,
  parameter bit STEP_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_access,
  input  logic             reg_we,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             step_go,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
    MEMORY = 3'd4, WRITE = 3'd5, PAUSE = 3'd6, HALT = 3'd7
  } st_e;
  st_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic ready, stall, timeout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    ready     = state_q == FETCH ? imem_ready : (!mem_access || dmem_ready);
    stall     = (state_q == FETCH || state_q == MEMORY) && !ready;
    timeout   = stall && TIMEOUT != 0 && wait_q == TO_V;
    state_d   = state_q;
    case (state_q)
      IDLE:           state_d = FETCH;
      FETCH:          state_d = ready ? DECODE : timeout ? HALT : FETCH;
      DECODE:         state_d = halt_req ? HALT : EXECUTE;
      EXECUTE:        state_d = MEMORY;
      MEMORY:         state_d = ready ? WRITE : timeout ? HALT : MEMORY;
      WRITE:          state_d = STEP_EN && step_mode ? PAUSE : FETCH;
      PAUSE:          state_d = !STEP_EN || step_go || !step_mode ? FETCH : PAUSE;
      default:        state_d = HALT;
    endcase
    wait_d    = state_d != state_q ? '0 : stall && !(&wait_q) ? wait_q + 1'b1 : wait_q;
    bus_err_d = bus_err_q | timeout;
    cycle_d   = state_q == HALT ? cycle_q : cycle_q + 1'b1;
    instret_d = state_q == WRITE ? instret_q + 1'b1 : instret_q;
  end
  always_comb begin
    if_en  = state_q == FETCH;
    id_en  = state_q == DECODE;
    exe_en = state_q == EXECUTE || state_q == MEMORY || state_q == WRITE;
    mem_en = state_q == MEMORY || state_q == WRITE;
    pc_en  = state_q == WRITE;
    wb_en  = state_q == WRITE && reg_we;
    halted = state_q == HALT;
  end
  assign state       = state_q;
  assign bus_err     = bus_err_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed stimulus checked every cycle against a stage-level model plus literal pins
module tb_cpu_sequencer;
  localparam int TO = 15;
  logic clk = 0, rst = 1;
  logic imem_ready = 1, dmem_ready = 1, mem_access = 0, reg_we = 1;
  logic halt_req = 0, step_mode = 0, step_go = 0;
  logic if_en, id_en, exe_en, mem_en, wb_en, pc_en, halted, bus_err;
  logic [2:0] state;
  logic [31:0] cycle_cnt, instret_cnt;
  logic s_if_en, s_id_en, s_exe_en, s_mem_en, s_wb_en, s_pc_en, s_halted, s_bus_err;
  logic [2:0] s_state;
  logic [3:0] s_cyc, s_ret;
  int n_cmp = 0, n_bad = 0;
  bit go = 0;
  int m_state = 0, m_wait = 0;
  bit m_err = 0;
  int unsigned m_cyc = 0, m_ret = 0;
  int np = 0;
  int pin_sel [8];
  logic [31:0] pin_val [8];
  string pin_nm [8];

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .mem_access(mem_access), .reg_we(reg_we), .halt_req(halt_req),
    .step_mode(step_mode), .step_go(step_go), .if_en(if_en), .id_en(id_en),
    .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
    .state(state), .halted(halted), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .mem_access(mem_access), .reg_we(reg_we), .halt_req(halt_req),
    .step_mode(step_mode), .step_go(step_go), .if_en(s_if_en), .id_en(s_id_en),
    .exe_en(s_exe_en), .mem_en(s_mem_en), .wb_en(s_wb_en), .pc_en(s_pc_en),
    .state(s_state), .halted(s_halted), .bus_err(s_bus_err),
    .cycle_cnt(s_cyc), .instret_cnt(s_ret)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int s, int w);
    if (s == 0) return 1;
    if (s == 1) return imem_ready ? 2 : (w == TO ? 7 : 1);
    if (s == 2) return halt_req ? 7 : 3;
    if (s == 3) return 4;
    if (s == 4) return (!mem_access || dmem_ready) ? 5 : (w == TO ? 7 : 4);
    if (s == 5) return step_mode ? 6 : 1;
    if (s == 6) return (step_go || !step_mode) ? 1 : 6;
    return 7;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_wait  <= 0;
      m_err   <= 0;
      m_cyc   <= 0;
      m_ret   <= 0;
    end else if (m_state != 7) begin
      m_state <= model_next(m_state, m_wait);
      m_wait  <= model_next(m_state, m_wait) == m_state ? m_wait + 1 : 0;
      m_err   <= m_err | (model_next(m_state, m_wait) == 7 && (m_state == 1 || m_state == 4));
      m_cyc   <= m_cyc + 1;
      m_ret   <= m_ret + (m_state == 5 ? 1 : 0);
    end
  end

  function automatic logic [31:0] get(int sel);
    case (sel)
      0: return 32'(state);
      1: return cycle_cnt;
      2: return instret_cnt;
      3: return 32'(bus_err);
      4: return 32'(halted);
      5: return 32'(pc_en);
      6: return 32'(wb_en);
      7: return 32'(s_ret);
      default: return 32'(s_cyc);
    endcase
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      cmp("state", 32'(state), 32'(m_state));
      cmp("if_en", 32'(if_en), 32'(m_state == 1));
      cmp("id_en", 32'(id_en), 32'(m_state == 2));
      cmp("exe_en", 32'(exe_en), 32'(m_state >= 3 && m_state <= 5));
      cmp("mem_en", 32'(mem_en), 32'(m_state == 4 || m_state == 5));
      cmp("pc_en", 32'(pc_en), 32'(m_state == 5));
      cmp("wb_en", 32'(wb_en), 32'(m_state == 5 && reg_we));
      cmp("halted", 32'(halted), 32'(m_state == 7));
      cmp("bus_err", 32'(bus_err), 32'(m_err));
      cmp("cycle_cnt", cycle_cnt, m_cyc);
      cmp("instret_cnt", instret_cnt, m_ret);
      cmp("w4_state", 32'(s_state), 32'(m_state));
      cmp("w4_cycle_cnt", 32'(s_cyc), m_cyc % 16);
      cmp("w4_instret_cnt", 32'(s_ret), m_ret % 16);
      for (int i = 0; i < np; i++) cmp(pin_nm[i], get(pin_sel[i]), pin_val[i]);
    end
  end

  task automatic pin(string nm, int sel, logic [31:0] v);
    pin_nm[np] = nm;
    pin_sel[np] = sel;
    pin_val[np] = v;
    np++;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      np = 0;
    end
  endtask

  initial begin
    step(1);
    go = 1;
    pin("rst_state", 0, 0); pin("rst_cyc", 1, 0); pin("rst_ret", 2, 0); pin("rst_err", 3, 0);
    step(1);
    rst = 0;
    step(4);
    pin("t1_write1", 0, 5); pin("t1_pc1", 5, 1); pin("t1_wb1", 6, 1);
    step(1);
    step(4);
    pin("t1_write2", 0, 5); pin("t1_pc2", 5, 1);
    step(1);
    step(2);
    pin("t1_cyc13", 1, 13); pin("t1_ret2", 2, 2); pin("t1_state13", 0, 3);
    step(1);
    imem_ready = 0;
    step(5);
    pin("t2_fetch4", 0, 1);
    step(1);
    imem_ready = 1;
    pin("t2_decode", 0, 2); pin("t2_err", 3, 0);
    step(1);
    mem_access = 1;
    dmem_ready = 0;
    step(16);
    pin("t3_mem16", 0, 4);
    step(1);
    pin("t3_halt", 0, 7); pin("t3_err", 3, 1); pin("t3_halted", 4, 1);
    pin("t3_cyc", 1, 38); pin("t3_ret", 2, 3);
    step(1);
    imem_ready = 0;
    dmem_ready = 1;
    halt_req = 1;
    step(6);
    pin("t3_frozen_cyc", 1, 38); pin("t3_absorb", 0, 7);
    step(1);
    rst = 1;
    imem_ready = 1;
    dmem_ready = 0;
    halt_req = 0;
    pin("t3_rst_state", 0, 0); pin("t3_rst_err", 3, 0); pin("t3_rst_cyc", 1, 0); pin("t3_rst_ret", 2, 0);
    step(1);
    rst = 0;
    step(19);
    dmem_ready = 1;
    pin("rw_write", 0, 5); pin("rw_err", 3, 0);
    step(1);
    mem_access = 0;
    step_mode = 1;
    step_go = 1;
    step(1);
    step_go = 0;
    pin("t4_pause", 0, 6); pin("t4_pc0", 5, 0);
    step(1);
    step(19);
    pin("t4_pause20", 0, 6); pin("t4_cyc", 1, 42); pin("t4_ret1", 2, 1);
    step(1);
    step_go = 1;
    reg_we = 0;
    pin("t4_go_fetch", 0, 1);
    step(1);
    step_go = 0;
    step(3);
    pin("t4_write", 0, 5); pin("t4_pc", 5, 1); pin("t4_wb0", 6, 0);
    step(1);
    pin("t4_repause", 0, 6); pin("t4_ret2", 2, 2);
    step(1);
    step(2);
    pin("t4_hold", 0, 6); pin("t4_hold_ret", 2, 2);
    step(1);
    step_mode = 0;
    reg_we = 1;
    pin("t4_resume", 0, 1);
    step(1);
    halt_req = 1;
    step(1);
    pin("t5_halt", 0, 7); pin("t5_halted", 4, 1); pin("t5_ret", 2, 2); pin("t5_err", 3, 0);
    step(1);
    step(3);
    pin("t5_frozen", 1, 54); pin("t5_absorb", 0, 7);
    step(1);
    rst = 1;
    halt_req = 0;
    step(1);
    rst = 0;
    step(100);
    pin("t6_ret", 2, 20); pin("t6_cyc", 1, 101); pin("t6_w4_ret", 7, 4); pin("t6_w4_cyc", 8, 5);
    step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Parametrised multi-cycle stage sequencer for the RISC-V core; replaces the fixed six-state fetch/decode/execute/memory/write loop.
- Adds memory ready handshakes with wait states, a bus-timeout error halt, a single-step debug mode, and cycle/retired-instruction counters.
- Drives the per-stage enables consumed by instruction memory, register file, control, data memory and program counter.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt.
- TIMEOUT, 15, max consecutive not-ready cycles tolerated in FETCH or MEMORY; 0 disables the timeout.
- STEP_EN, 1, 1 = single-step logic present; 0 = step_mode/step_go ignored.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction memory has valid instruction this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- mem_access  in  1  decoded instruction is a load/store (from control).
- reg_we  in  1  decoded instruction writes rd (from control).
- halt_req  in  1  halt/ecall decode flag (from control).
- step_mode  in  1  debug single-step enable (from switches).
- step_go  in  1  one-cycle pulse: release one instruction.
- if_en  out  1  fetch enable.
- id_en  out  1  decode/register-read enable.
- exe_en  out  1  execute enable (held through MEMORY, WRITE).
- mem_en  out  1  data memory enable (held through WRITE).
- wb_en  out  1  register write enable.
- pc_en  out  1  program counter update enable.
- state  out  3  current state code.
- halted  out  1  core stopped (HALT state).
- bus_err  out  1  sticky timeout flag.
- cycle_cnt  out  CNT_W  cycles elapsed since reset.
- instret_cnt  out  CNT_W  instructions retired.

Behaviour:
- State codes: IDLE=000, FETCH=001, DECODE=010, EXECUTE=011, MEMORY=100, WRITE=101, PAUSE=110, HALT=111.
- Moore machine: every enable is decoded from the state register only; the single exception is wb_en = (state==WRITE) & reg_we.
- Reset (sync): state=IDLE; halted=0; bus_err=0; both counters=0; wait counter=0; all enables 0.
- rst has priority over every other input in any state, including HALT and mid-wait.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH: if_en=1.
  - imem_ready=1 -> DECODE.
  - Otherwise stay; wait counter increments.
  - If TIMEOUT!=0 and wait counter == TIMEOUT while still not ready -> HALT, bus_err=1.
  - Each fetch completes in at least one cycle.
- DECODE: id_en=1; halt_req=1 -> HALT (no retire, pc_en never pulses); else -> EXECUTE.
- EXECUTE: exe_en=1; -> MEMORY.
- MEMORY: exe_en=mem_en=1.
  - mem_access=0 -> WRITE.
  - mem_access=1: wait for dmem_ready with the same wait-counter/timeout rule as FETCH; ready -> WRITE.
- WRITE: exe_en=mem_en=pc_en=1; wb_en as above; instret_cnt += 1.
  - Next state: PAUSE if STEP_EN && step_mode, else FETCH.
- PAUSE: all enables 0.
  - step_go=1 or step_mode=0 -> FETCH; else stay.
  - step_go outside PAUSE is ignored (not latched).
- HALT: absorbing until rst; halted=1; all enables 0; counters frozen.
- Wait counter: width clog2(TIMEOUT+1) (min 1); cleared on every state transition; saturates, never wraps.
- cycle_cnt increments every cycle state != HALT (including IDLE and PAUSE); wraps modulo 2^CNT_W.
- instret_cnt wraps modulo 2^CNT_W.
- Ready inputs are only sampled in their own stage; a ready that is high early is not remembered.
- Simultaneous ready and timeout on the same cycle: ready wins (transition forward, no error).

Test Plan:
- Reset, imem_ready=dmem_ready=1, mem_access=0, reg_we=1, step_mode=0, run 13 cycles -> states 0,1,2,3,4,5,1,2,…; pc_en/wb_en high on cycles 6 and 11; instret_cnt=2; cycle_cnt=13.
- imem_ready held 0 for 3 cycles in FETCH -> FETCH persists 4 cycles, then DECODE; bus_err=0.
- TIMEOUT=15, mem_access=1, dmem_ready stuck 0 -> HALT entered after 16 MEMORY cycles; bus_err=1; halted=1; counters frozen; rst -> IDLE, bus_err=0.
- step_mode=1 -> after WRITE, state=110 with all enables 0 for 20 cycles; cycle_cnt still advances; step_go pulse -> FETCH next cycle; exactly one more retire before returning to PAUSE.
- halt_req=1 in DECODE -> HALT next cycle; pc_en never pulsed; instret_cnt unchanged.
- CNT_W=4 build, 20 instructions at one-cycle memories -> instret_cnt wraps to 4; cycle_cnt wraps consistently.
